// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: default width, FSM states and
// the bit-counter width helper.
package serial_adder_ctrl_pkg;

  localparam int unsigned ADD_W = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the bit-serial adder; master drives the operands,
// slave (the adder) returns status and result.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned W = ADD_W
) ();

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// 1-bit full-adder cell used once by the serial adder.
module serial_adder_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic s
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: streams latched operands LSB-first through one
// full-adder cell and reassembles the sum in a shift register.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned W = ADD_W
) (
  input logic            clk,
  input logic            rst_n,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CntMsb  = CNT_W'(W - 2);

  state_e           state;
  logic [W-1:0]     sh_a;
  logic [W-1:0]     sh_b;
  logic [W-1:0]     sh_sum;
  logic [W-1:0]     sum;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             c_msb_in;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;
  logic             fa_s;
  logic             fa_c;

  serial_adder_ctrl_fa u_fa (
    .a  (sh_a[0]),
    .b  (sh_b[0]),
    .ci (carry),
    .co (fa_c),
    .s  (fa_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      sh_a     <= '0;
      sh_b     <= '0;
      sh_sum   <= '0;
      sum      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (bus.start) begin
            sh_a  <= bus.a;
            sh_b  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StShift;
          end else begin
            state <= StIdle;
          end
        end
        StShift: begin
          carry  <= fa_c;
          sh_sum <= {fa_s, sh_sum[W-1:1]};
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          cnt    <= cnt + 1'b1;
          // Carry out of bit W-2 is the carry into the sign bit.
          if (cnt == CntMsb) begin
            c_msb_in <= fa_c;
          end
          if (cnt == CntLast) begin
            sum   <= {fa_s, sh_sum[W-1:1]};
            cout  <= fa_c;
            ovf   <= c_msb_in ^ fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum;
  assign bus.cout = cout;
  assign bus.ovf  = ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vectors at W=8, corner
// sequences, and randomized operands at W=4 and W=16 against an arithmetic model.
module tb_serial_adder_ctrl;
  import serial_adder_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.W(8))  bus8  ();
  serial_adder_ctrl_if #(.W(4))  bus4  ();
  serial_adder_ctrl_if #(.W(16)) bus16 ();

  serial_adder_ctrl #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_ctrl #(.W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  serial_adder_ctrl #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cout;
    logic        ovf;
    logic [31:0] sum;
  } obs_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic cin);
    case (w)
      4:  begin bus4.start = st;  bus4.a = a[3:0];   bus4.b = b[3:0];   bus4.cin = cin;  end
      16: begin bus16.start = st; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.cin = cin; end
      default: begin bus8.start = st; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = cin; end
    endcase
  endtask

  function automatic obs_t obs(input int w);
    obs_t o;
    o = '0;
    case (w)
      4:  o = '{bus4.busy, bus4.done, bus4.cout, bus4.ovf, 32'(bus4.sum)};
      16: o = '{bus16.busy, bus16.done, bus16.cout, bus16.ovf, 32'(bus16.sum)};
      default: o = '{bus8.busy, bus8.done, bus8.cout, bus8.ovf, 32'(bus8.sum)};
    endcase
    return o;
  endfunction

  // Plain integer addition; overflow from the operand and result sign bits.
  function automatic logic [33:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin);
    logic [31:0] mask, am, bm, s;
    logic [32:0] full;
    logic        ov;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    am   = a & mask;
    bm   = b & mask;
    full = {1'b0, am} + {1'b0, bm} + {32'h0, cin};
    s    = full[31:0] & mask;
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ov, full[w], s};
  endfunction

  // One complete add: returns result, edges from accept to done, busy-cycle count and
  // whether the held outputs stayed put until done.
  task automatic do_add(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin,
                        output obs_t res, output int lat, output int busyc, output bit hold_ok);
    obs_t prev, o;
    @(negedge clk);
    prev = obs(w);
    drive(w, 1'b1, a, b, cin);
    @(posedge clk);
    #1;
    drive(w, 1'b0, $urandom, $urandom, 1'($urandom));
    lat = 0;
    busyc = 0;
    hold_ok = 1'b1;
    o = obs(w);
    while (!o.done && lat < 100) begin
      if (o.busy) busyc++;
      if ({o.cout, o.ovf, o.sum} !== {prev.cout, prev.ovf, prev.sum}) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      o = obs(w);
    end
    res = o;
  endtask

  vec_t vecs[8];
  obs_t o;
  int   lat, busyc, dones, last_done, gap_bad, sum_bad;
  bit   hold_ok;
  logic [33:0] exp;
  logic [31:0] ra, rb;
  logic        rc;

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};

    drive(4, 1'b0, 0, 0, 1'b0);
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(16, 1'b0, 0, 0, 1'b0);
    #1;
    check("reset_outputs_w8", 64'(obs(8)), 64'(obs_t'('0)));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset_w8", 64'(obs(8)), 64'(obs_t'('0)));

    // Directed vectors; latency W edges after accept = done in cycle W+1 from the request.
    for (int i = 0; i < 8; i++) begin
      do_add(8, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, o, lat, busyc, hold_ok);
      check($sformatf("vec%0d_result", i), {o.ovf, o.cout, o.sum},
            {vecs[i].ovf, vecs[i].cout, 24'h0, vecs[i].sum});
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_busy_cycles", i), busyc, 8);
      check($sformatf("vec%0d_hold", i), hold_ok, 1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), obs(8).done, 1'b0);
    end

    // Start pulse mid-SHIFT is ignored.
    @(negedge clk);
    drive(8, 1'b1, 32'h10, 32'h20, 1'b0);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 0, 0, 1'b0);
    busyc = 0;
    dones = 0;
    o = obs(8);
    for (int k = 0; k < 30; k++) begin
      if (o.busy) busyc++;
      if (o.done) begin
        dones++;
        check("ignore_start_sum", o.sum, 32'h30);
      end
      if (k == 3) drive(8, 1'b1, 32'hFF, 32'h20, 1'b0);
      else        drive(8, 1'b0, 0, 0, 1'b0);
      @(posedge clk);
      #1;
      o = obs(8);
    end
    check("ignore_start_dones", dones, 1);
    check("ignore_start_busy_cycles", busyc, 8);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    drive(8, 1'b1, 32'h5A, 32'h3C, 1'b0);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midshift_reset_outputs", 64'(obs(8)), 64'(obs_t'('0)));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (obs(8).done || obs(8).busy) dones++;
    end
    check("midshift_reset_no_done", dones, 0);
    do_add(8, 32'd1, 32'd2, 1'b0, o, lat, busyc, hold_ok);
    check("after_reset_1p2", {o.done, o.ovf, o.cout, o.sum}, {3'b100, 32'd3});

    // Start held high: one result every W+1 cycles.
    @(negedge clk);
    drive(8, 1'b1, 32'h5A, 32'h3C, 1'b0);
    dones = 0;
    last_done = -1;
    gap_bad = 0;
    sum_bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      o = obs(8);
      if (o.done) begin
        if (last_done >= 0 && k - last_done != 9) gap_bad++;
        last_done = k;
        dones++;
      end
      if (dones > 0 && o.sum !== 32'h96) sum_bad++;
    end
    drive(8, 1'b0, 0, 0, 1'b0);
    check("backtoback_dones", dones, 5);
    check("backtoback_gap_errors", gap_bad, 0);
    check("backtoback_sum_unstable", sum_bad, 0);
    repeat (12) @(posedge clk);

    // Randomized operands at the narrow and wide widths.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      do_add(4, ra, rb, rc, o, lat, busyc, hold_ok);
      exp = ref_add(4, ra, rb, rc);
      check($sformatf("w4_rand%0d a=%0h b=%0h c=%0b", i, ra[3:0], rb[3:0], rc),
            {o.ovf, o.cout, o.sum}, exp);
      if (i < 4) check($sformatf("w4_latency%0d", i), lat, 4);
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      if (i == 0) begin ra = 32'h8000; rb = 32'h8000; rc = 1'b0; end
      if (i == 1) begin ra = 32'h7FFF; rb = 32'h0000; rc = 1'b1; end
      do_add(16, ra, rb, rc, o, lat, busyc, hold_ok);
      exp = ref_add(16, ra, rb, rc);
      check($sformatf("w16_rand%0d a=%0h b=%0h c=%0b", i, ra[15:0], rb[15:0], rc),
            {o.ovf, o.cout, o.sum}, exp);
      if (i < 4) begin
        check($sformatf("w16_latency%0d", i), lat, 16);
        check($sformatf("w16_hold%0d", i), hold_ok, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
